// File: rtl/arcade_ctl_pkg.sv
// Shared types for the arcade control sequencer: channel modes and reset
// sequencer states.
package arcade_ctl_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RETRIG  = 2'b01,
        MODE_FOLLOW  = 2'b10,
        MODE_TOGGLE  = 2'b11
    } trig_mode_t;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'b00,
        ST_HOLD   = 2'b01,
        ST_RUN    = 2'b10
    } rst_state_t;

endpackage

// File: rtl/arcade_trig_chan.sv
// One trigger channel: rising-edge detect feeding a one-shot/retrigger stretch
// counter, a follow register or a toggle latch, selected by a 2-bit mode.
module arcade_trig_chan
    import arcade_ctl_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] len,
    output logic             pulse
);

    trig_mode_t       mode_cur;
    trig_mode_t       mode_q;
    trig_mode_t       mode_nxt;
    logic             prev;
    logic             prev_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             latch;
    logic             latch_nxt;
    logic             follow;
    logic             follow_nxt;
    logic             rise;

    always_comb begin
        mode_cur   = trig_mode_t'(mode);
        rise       = trig & ~prev;
        prev_nxt   = trig;
        cnt_nxt    = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        latch_nxt  = latch;
        follow_nxt = trig;
        mode_nxt   = mode_q;

        // A mode switch flushes all state and resyncs prev so no edge is seen
        if (mode_cur != mode_q) begin
            cnt_nxt    = '0;
            latch_nxt  = 1'b0;
            follow_nxt = 1'b0;
            mode_nxt   = mode_cur;
        end else begin
            case (mode_q)
                MODE_ONESHOT: if (rise && cnt == '0) cnt_nxt = len;
                MODE_RETRIG:  if (rise) cnt_nxt = len;
                MODE_TOGGLE:  if (rise) latch_nxt = ~latch;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= MODE_ONESHOT;
            prev   <= 1'b0;
            cnt    <= '0;
            latch  <= 1'b0;
            follow <= 1'b0;
        end else begin
            mode_q <= mode_nxt;
            prev   <= prev_nxt;
            cnt    <= cnt_nxt;
            latch  <= latch_nxt;
            follow <= follow_nxt;
        end
    end

    // Output is a pure function of registered state
    always_comb begin
        pulse = 1'b0;
        case (mode_q)
            MODE_ONESHOT, MODE_RETRIG: pulse = (cnt != '0);
            MODE_FOLLOW:               pulse = follow;
            MODE_TOGGLE:               pulse = latch;
            default:                   pulse = 1'b0;
        endcase
    end

endmodule

// File: rtl/arcade_ctl_seq.sv
// Control sequencer for arcade cores: N conditioned trigger channels plus a
// core reset generator with a minimum hold after all sources release.
module arcade_ctl_seq
    import arcade_ctl_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 20,
    parameter int RST_SRCS = 3,
    parameter int RST_HOLD = 16
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       trig_i,
    input  logic [2*CHANNELS-1:0]     mode_i,
    input  logic [CHANNELS*CNT_W-1:0] len_i,
    output logic [CHANNELS-1:0]       trig_o,
    input  logic [RST_SRCS-1:0]       rst_src_i,
    output logic                      core_reset_o,
    output logic                      rst_done_o
);

    localparam int HCNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        arcade_trig_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk_sys),
            .reset_n (reset_n),
            .trig    (trig_i[g]),
            .mode    (mode_i[2*g +: 2]),
            .len     (len_i[g*CNT_W +: CNT_W]),
            .pulse   (trig_o[g])
        );
    end

    rst_state_t        state;
    rst_state_t        state_nxt;
    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hcnt_nxt;
    logic              done_nxt;
    logic              any_src;

    always_comb begin
        any_src   = |rst_src_i;
        state_nxt = state;
        hcnt_nxt  = hcnt;
        done_nxt  = 1'b0;
        case (state)
            ST_ASSERT: begin
                if (!any_src) begin
                    state_nxt = ST_HOLD;
                    hcnt_nxt  = HCNT_W'(RST_HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (any_src) begin
                    state_nxt = ST_ASSERT;
                end else if (hcnt == '0) begin
                    state_nxt = ST_RUN;
                    done_nxt  = 1'b1;
                end else begin
                    hcnt_nxt = hcnt - HCNT_W'(1);
                end
            end
            ST_RUN: begin
                if (any_src) state_nxt = ST_ASSERT;
            end
            default: state_nxt = ST_ASSERT;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_ASSERT;
            hcnt       <= '0;
            rst_done_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            hcnt       <= hcnt_nxt;
            rst_done_o <= done_nxt;
        end
    end

    // Decoded straight from the state register, so it asserts with reset_n
    assign core_reset_o = (state != ST_RUN);

endmodule

// File: tb/tb_arcade_ctl_seq.sv
// Directed bench for arcade_ctl_seq: channel modes, stretch saturation,
// reset hold/restart and asynchronous reset behaviour.
module tb_arcade_ctl_seq;

    localparam int CHANNELS = 4;
    localparam int CNT_W    = 4;
    localparam int RST_SRCS = 3;
    localparam int RST_HOLD = 16;

    logic                      clk_sys = 1'b0;
    logic                      reset_n;
    logic [CHANNELS-1:0]       trig_i;
    logic [2*CHANNELS-1:0]     mode_i;
    logic [CHANNELS*CNT_W-1:0] len_i;
    logic [CHANNELS-1:0]       trig_o;
    logic [RST_SRCS-1:0]       rst_src_i;
    logic                      core_reset_o;
    logic                      rst_done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt;
    int done_cnt;
    int done_idx;
    int first_low;
    int ones;
    logic at_5;
    logic at_6;

    arcade_ctl_seq #(
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W),
        .RST_SRCS (RST_SRCS),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .trig_i       (trig_i),
        .mode_i       (mode_i),
        .len_i        (len_i),
        .trig_o       (trig_o),
        .rst_src_i    (rst_src_i),
        .core_reset_o (core_reset_o),
        .rst_done_o   (rst_done_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        trig_i    = '0;
        mode_i    = '0;
        len_i     = '0;
        rst_src_i = '0;
        #2;
        check("rst_trig_o", 32'(trig_o), 0);
        check("rst_core_reset", 32'(core_reset_o), 1);
        check("rst_done", 32'(rst_done_o), 0);
        tick();
        tick();
        check("rst_held_core_reset", 32'(core_reset_o), 1);

        // Release with no sources: core reset stays up 16 cycles, single done pulse
        reset_n = 1'b1;
        hi_cnt = 0; done_cnt = 0; done_idx = -1;
        for (int k = 0; k < 22; k++) begin
            tick();
            if (core_reset_o) hi_cnt++;
            if (rst_done_o) begin done_cnt++; done_idx = k; end
        end
        check("hold_high_cycles", 32'(hi_cnt), 16);
        check("hold_done_count", 32'(done_cnt), 1);
        check("hold_done_index", 32'(done_idx), 16);

        // One-shot ch0 len=5, second edge mid-stretch ignored, len change ignored
        len_i[3:0] = 4'd5;
        trig_i[0] = 1'b1;
        ones = 0; at_5 = 1'b0; at_6 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (trig_o[0]) ones++;
            if (k == 5) at_5 = trig_o[0];
            if (k == 6) at_6 = trig_o[0];
            if (k == 1) trig_i[0] = 1'b0;
            if (k == 2) begin trig_i[0] = 1'b1; len_i[3:0] = 4'd9; end
        end
        check("oneshot_ones", 32'(ones), 5);
        check("oneshot_last_high", 32'(at_5), 1);
        check("oneshot_first_low", 32'(at_6), 0);
        trig_i[0] = 1'b0;

        // Retrigger ch1 len=5, edges 3 cycles apart -> 8 continuous cycles
        mode_i[3:2] = 2'b01;
        len_i[7:4]  = 4'd5;
        tick();
        check("retrig_after_mode_change", 32'(trig_o[1]), 0);
        trig_i[1] = 1'b1;
        ones = 0; at_5 = 1'b0; at_6 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (trig_o[1]) ones++;
            if (k == 8) at_5 = trig_o[1];
            if (k == 9) at_6 = trig_o[1];
            if (k == 1) trig_i[1] = 1'b0;
            if (k == 3) trig_i[1] = 1'b1;
            if (k == 4) trig_i[1] = 1'b0;
        end
        check("retrig_ones", 32'(ones), 8);
        check("retrig_last_high", 32'(at_5), 1);
        check("retrig_first_low", 32'(at_6), 0);

        // len=0 never raises the output
        len_i[7:4] = 4'd0;
        trig_i[1] = 1'b1;
        ones = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (trig_o[1]) ones++;
        end
        check("retrig_len0", 32'(ones), 0);
        trig_i[1] = 1'b0;

        // Toggle ch2: three pulses give 1,0,1; switch to follow while high
        mode_i[5:4] = 2'b11;
        tick();
        trig_i[2] = 1'b1; tick();
        check("toggle_1", 32'(trig_o[2]), 1);
        trig_i[2] = 1'b0; tick();
        check("toggle_1_hold", 32'(trig_o[2]), 1);
        trig_i[2] = 1'b1; tick();
        check("toggle_2", 32'(trig_o[2]), 0);
        trig_i[2] = 1'b0; tick();
        trig_i[2] = 1'b1; tick();
        check("toggle_3", 32'(trig_o[2]), 1);
        mode_i[5:4] = 2'b10;
        tick();
        check("follow_switch_low", 32'(trig_o[2]), 0);
        tick();
        check("follow_high", 32'(trig_o[2]), 1);
        trig_i[2] = 1'b0; tick();
        check("follow_low", 32'(trig_o[2]), 0);

        // Saturation ch3: CNT_W=4, len=15 -> exactly 15 high cycles, no wrap
        len_i[15:12] = 4'd15;
        trig_i[3] = 1'b1;
        ones = 0; at_5 = 1'b0; at_6 = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (trig_o[3]) ones++;
            if (k == 15) at_5 = trig_o[3];
            if (k == 16) at_6 = trig_o[3];
            if (k == 1) trig_i[3] = 1'b0;
        end
        check("sat_ones", 32'(ones), 15);
        check("sat_last_high", 32'(at_5), 1);
        check("sat_first_low", 32'(at_6), 0);

        // Source asserted in RUN, then a re-assert during HOLD restarts the hold
        check("run_core_reset", 32'(core_reset_o), 0);
        rst_src_i[2] = 1'b1;
        tick();
        check("run_src_core_reset", 32'(core_reset_o), 1);
        rst_src_i[2] = 1'b0;
        hi_cnt = 0; done_cnt = 0; done_idx = -1; first_low = -1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (core_reset_o) hi_cnt++;
            else if (first_low < 0) first_low = k;
            if (rst_done_o) begin done_cnt++; done_idx = k; end
            if (k == 10) rst_src_i[2] = 1'b1;
            if (k == 11) rst_src_i[2] = 1'b0;
        end
        check("restart_high_cycles", 32'(hi_cnt), 27);
        check("restart_first_low", 32'(first_low), 28);
        check("restart_done_count", 32'(done_cnt), 1);
        check("restart_done_index", 32'(done_idx), 28);

        // Asynchronous reset mid-stretch while in RUN, no clock edge involved
        len_i[3:0] = 4'd5;
        trig_i[0] = 1'b1;
        tick();
        tick();
        check("pre_async_trig", 32'(trig_o[0]), 1);
        check("pre_async_core_reset", 32'(core_reset_o), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_trig_o", 32'(trig_o), 0);
        check("async_core_reset", 32'(core_reset_o), 1);
        check("async_done", 32'(rst_done_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
